// File: rtl/fastspk_rate_meter.sv
// rtl/fastspk_rate_meter.sv - edge-rate meter and stall kicker for the fast spike oscillator
//
// Counts rising edges of the free-running spike oscillator output, carries the
// count into sysClk as a Gray code, and reports edges per programmable window.
// A run of zero-count windows flags the oscillator as stalled and pulses kick
// towards the oscillator stage to restart it.
//
// Optional build macro: RATE_AVG_EN. When defined, rate carries a smoothed
// value (rate += (delta - rate) / 4, signed); the first window after leaving
// IDLE loads the raw count. Stall detection always uses the raw count.
//
// Ports:
//   sysClk      in   system clock
//   reset       in   asynchronous, active-high reset
//   spk_in      in   spike train, asynchronous to sysClk, counted on rising edge
//   enable      in   0 holds the measurement FSM in IDLE
//   win_len     in   window length in sysClk cycles (values below 4 act as 4)
//   rate        out  edges counted in the last completed window
//   rate_valid  out  one-cycle pulse accompanying each new rate value
//   stalled     out  oscillator considered dead
//   kick        out  restart request to the oscillator stage

`timescale 1ns/1ps

module fastspk_rate_meter #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int STALL_WINDOWS = 2,
  parameter int KICK_LEN      = 8
) (
  input  logic             sysClk,
  input  logic             reset,
  input  logic             spk_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             stalled,
  output logic             kick
);

  localparam int ZW = $clog2(STALL_WINDOWS + 1);
  localparam int KW = $clog2(KICK_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_MEASURE,
    ST_REPORT
  } state_t;

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------- spike domain
  // The Gray register is loaded with the encoding of the incremented count on
  // the same edge, so it always equals the current count and changes one bit
  // per edge -- the only property the crossing relies on.
  logic [CNT_W-1:0] spk_bin_q, spk_bin_d;
  logic [CNT_W-1:0] spk_gray_q, spk_gray_d;

  always_comb begin
    spk_bin_d  = spk_bin_q + CNT_W'(1);
    spk_gray_d = spk_bin_d ^ (spk_bin_d >> 1);
  end

  always_ff @(posedge spk_in or posedge reset) begin
    if (reset) begin
      spk_bin_q  <= '0;
      spk_gray_q <= '0;
    end else begin
      spk_bin_q  <= spk_bin_d;
      spk_gray_q <= spk_gray_d;
    end
  end

  // ---------------------------------------------------------------- sysClk domain
  logic [CNT_W-1:0] sync1_q, sync1_d;
  logic [CNT_W-1:0] sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] prev_cnt_q, prev_cnt_d;
  logic [WIN_W-1:0] win_ctr_q, win_ctr_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic [ZW-1:0]    zero_ctr_q, zero_ctr_d;
  logic             stalled_q, stalled_d;
  logic [KW-1:0]    kick_ctr_q, kick_ctr_d;

  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] delta;
  logic [WIN_W-1:0] win_load;
  logic [CNT_W-1:0] rate_next;

  assign cur_cnt  = gray2bin(sync2_q);
  // Modular difference absorbs counter wrap within one window.
  assign delta    = cur_cnt - prev_cnt_q;
  // Countdown reload: window of N cycles runs the counter N-1 .. 0.
  assign win_load = (win_len < WIN_W'(4)) ? WIN_W'(3) : (win_len - WIN_W'(1));

`ifdef RATE_AVG_EN
  logic                    first_q, first_d;
  logic signed [CNT_W:0]   avg_diff;
  logic signed [CNT_W:0]   avg_step;

  always_comb begin
    avg_diff  = $signed({1'b0, delta}) - $signed({1'b0, rate_q});
    avg_step  = avg_diff >>> 2;
    rate_next = first_q ? delta : (rate_q + avg_step[CNT_W-1:0]);
    first_d   = first_q;
    if (state_q == ST_PRIME) begin
      first_d = 1'b1;
    end else if (state_q == ST_REPORT) begin
      first_d = 1'b0;
    end
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      first_q <= 1'b1;
    end else begin
      first_q <= first_d;
    end
  end
`else
  assign rate_next = delta;
`endif

  always_comb begin
    sync1_d      = spk_gray_q;
    sync2_d      = sync1_q;
    state_d      = state_q;
    prev_cnt_d   = prev_cnt_q;
    win_ctr_d    = win_ctr_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    zero_ctr_d   = zero_ctr_q;
    stalled_d    = stalled_q;
    // A running kick always completes, independent of FSM state.
    kick_ctr_d   = (kick_ctr_q != '0) ? (kick_ctr_q - KW'(1)) : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        prev_cnt_d = cur_cnt;
        win_ctr_d  = win_load;
        state_d    = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (win_ctr_q == '0) begin
          state_d = ST_REPORT;
        end else begin
          win_ctr_d = win_ctr_q - WIN_W'(1);
        end
      end
      ST_REPORT: begin
        rate_d       = rate_next;
        rate_valid_d = 1'b1;
        prev_cnt_d   = cur_cnt;
        win_ctr_d    = win_load;
        state_d      = enable ? ST_MEASURE : ST_IDLE;
        if (delta == '0) begin
          // Restart the zero run after each kick so kicks repeat every
          // STALL_WINDOWS dead windows.
          if (zero_ctr_q == ZW'(STALL_WINDOWS - 1)) begin
            zero_ctr_d = '0;
            stalled_d  = 1'b1;
            kick_ctr_d = KW'(KICK_LEN);
          end else begin
            zero_ctr_d = zero_ctr_q + ZW'(1);
          end
        end else begin
          zero_ctr_d = '0;
          stalled_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      state_q      <= ST_IDLE;
      prev_cnt_q   <= '0;
      win_ctr_q    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      zero_ctr_q   <= '0;
      stalled_q    <= 1'b0;
      kick_ctr_q   <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      prev_cnt_q   <= prev_cnt_d;
      win_ctr_q    <= win_ctr_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      zero_ctr_q   <= zero_ctr_d;
      stalled_q    <= stalled_d;
      kick_ctr_q   <= kick_ctr_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign stalled    = stalled_q;
  assign kick       = (kick_ctr_q != '0);

endmodule

// File: tb/tb_fastspk_rate_meter.sv
// tb/tb_fastspk_rate_meter.sv - self-checking bench for fastspk_rate_meter

`timescale 1ns/1ps

module tb_fastspk_rate_meter;

  logic        sysClk = 1'b0;
  logic        reset;
  logic        spk_in = 1'b0;
  logic        enable;
  logic [15:0] win_len;
  logic [15:0] rate;
  logic        rate_valid;
  logic        stalled;
  logic        kick;

  int total = 0;
  int bad   = 0;

  // Spike stimulus: periodic mode (gen_half ns per half period, 0 = off) or
  // bursts of 1 ns half-period edges requested through burst_req.
  int edges      = 0;
  int edges_base = 0;
  int gen_half   = 0;
  int burst_req  = 0;
  int burst_done = 0;

  fastspk_rate_meter dut (
    .sysClk     (sysClk),
    .reset      (reset),
    .spk_in     (spk_in),
    .enable     (enable),
    .win_len    (win_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .stalled    (stalled),
    .kick       (kick)
  );

  always #5 sysClk = ~sysClk;

  always @(posedge spk_in) edges++;

  initial begin
    forever begin
      if (burst_done != burst_req) begin
        #1 spk_in = 1'b1;
        #1 spk_in = 1'b0;
        burst_done++;
      end else if (gen_half != 0) begin
        #(gen_half) spk_in = 1'b1;
        #(gen_half) spk_in = 1'b0;
      end else begin
        #1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
    total++;
    assert (((obs >= exp - tol) && (obs <= exp + tol)) === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
    end
  endtask

  // Returns the number of negedges waited until rate_valid is seen.
  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge sysClk);
      cyc++;
    end while (rate_valid !== 1'b1 && cyc < budget);
    if (rate_valid !== 1'b1) check("rate_valid_timeout", {31'd0, rate_valid}, 32'd1);
  endtask

  task automatic count_kick(output int n);
    n = 0;
    while (kick === 1'b1 && n < 40) begin
      n++;
      @(negedge sysClk);
    end
  endtask

  // Caller raises enable just after a negedge. Reference: a window of
  // max(win_len,4) cycles plus one report cycle; the rate of a window equals
  // the spike edges seen between consecutive pulses, within one edge.
  task automatic measure(input int wl, input int nwin, input string tag);
    int cyc;
    int e_prev;
    int eff;
    eff = (wl < 4) ? 4 : wl;
    wait_valid(eff + 10, cyc);
    check({tag, "_first_latency"}, cyc, eff + 3);
    e_prev = edges;
    for (int k = 0; k < nwin; k++) begin
      wait_valid(eff + 10, cyc);
      check({tag, "_period"}, cyc, eff + 1);
      check_tol({tag, "_rate"}, int'(rate), edges - e_prev, 1);
      e_prev = edges;
    end
  endtask

  initial begin
    int cyc;
    int nv;
    int n;
    int wl;
    int need;
    int found;
    logic [15:0] r0;

    reset   = 1'b1;
    enable  = 1'b0;
    win_len = 16'd100;
    repeat (3) @(negedge sysClk);
    check("reset_rate", {16'd0, rate}, 32'd0);
    check("reset_rate_valid", {31'd0, rate_valid}, 32'd0);
    check("reset_stalled", {31'd0, stalled}, 32'd0);
    check("reset_kick", {31'd0, kick}, 32'd0);
    reset      = 1'b0;
    edges_base = edges;

    // Spikes at 1/5 of sysClk, 100-cycle windows.
    gen_half = 25;
    win_len  = 16'd100;
    @(negedge sysClk) enable = 1'b1;
    measure(100, 4, "base");
    check_tol("base_rate_nominal", int'(rate), 20, 1);

    // Drop enable mid-window: window abandoned, rate held, then a full window.
    repeat (30) @(negedge sysClk);
    enable = 1'b0;
    r0 = rate;
    nv = 0;
    repeat (250) begin
      @(negedge sysClk);
      if (rate_valid === 1'b1) nv++;
    end
    check("abandon_no_valid", nv, 0);
    check("abandon_rate_hold", {16'd0, rate}, {16'd0, r0});
    @(negedge sysClk) enable = 1'b1;
    wait_valid(200, cyc);
    check("reenable_full_window", cyc, 103);
    @(negedge sysClk) enable = 1'b0;

    // Randomised spike periods and window lengths.
    for (int r = 0; r < 3; r++) begin
      gen_half = $urandom_range(10, 40);
      wl       = $urandom_range(20, 150);
      win_len  = 16'(wl);
      repeat (10) @(negedge sysClk);
      @(negedge sysClk) enable = 1'b1;
      measure(wl, 3, "rand");
      @(negedge sysClk) enable = 1'b0;
    end

    // Short win_len clamps to a 4-cycle window.
    gen_half = 5;
    win_len  = 16'd2;
    repeat (10) @(negedge sysClk);
    @(negedge sysClk) enable = 1'b1;
    measure(2, 4, "minwin");
    @(negedge sysClk) enable = 1'b0;

    // Counter wrap: bring the spike count to 0xFFF0, then 40 edges in one window.
    gen_half = 0;
    repeat (20) @(negedge sysClk);
    need = (32'h0000_FFF0 - (edges - edges_base)) & 32'h0000_FFFF;
    burst_req += need;
    wait (burst_done == burst_req);
    repeat (5) @(negedge sysClk);
    win_len = 16'd200;
    @(negedge sysClk) enable = 1'b1;
    wait_valid(220, cyc);
    burst_req += 40;
    wait_valid(220, cyc);
    check("wrap_period", cyc, 201);
    check("wrap_rate", {16'd0, rate}, 32'd40);
    @(negedge sysClk) enable = 1'b0;

    // Stall: no spikes, 20-cycle windows.
    repeat (20) @(negedge sysClk);
    win_len = 16'd20;
    @(negedge sysClk) enable = 1'b1;
    wait_valid(40, cyc);
    check("stall_w1_stalled", {31'd0, stalled}, 32'd0);
    check("stall_w1_kick", {31'd0, kick}, 32'd0);
    check("stall_w1_rate", {16'd0, rate}, 32'd0);
    wait_valid(40, cyc);
    check("stall_w2_stalled", {31'd0, stalled}, 32'd1);
    count_kick(n);
    check("kick_len", n, 8);
    wait_valid(40, cyc);
    check("stall_w3_kick", {31'd0, kick}, 32'd0);
    check("stall_w3_stalled", {31'd0, stalled}, 32'd1);
    wait_valid(40, cyc);
    check("stall_w4_kick", {31'd0, kick}, 32'd1);
    gen_half = 25;
    count_kick(n);
    check("rekick_completes", n, 8);
    wait_valid(40, cyc);
    check("recover_stalled", {31'd0, stalled}, 32'd0);
    check("recover_rate_nonzero", {31'd0, (rate != 16'd0)}, 32'd1);

    // Reset in the middle of a kick, between clock edges.
    gen_half = 0;
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      wait_valid(40, cyc);
      if (kick === 1'b1) found = 1;
    end
    check("second_stall_kick", found, 1);
    repeat (2) @(negedge sysClk);
    check("pre_reset_kick", {31'd0, kick}, 32'd1);
    check("pre_reset_stalled", {31'd0, stalled}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_kick", {31'd0, kick}, 32'd0);
    check("async_reset_stalled", {31'd0, stalled}, 32'd0);
    check("async_reset_rate", {16'd0, rate}, 32'd0);
    check("async_reset_rate_valid", {31'd0, rate_valid}, 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge sysClk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
